// File: rtl/branch_predict_unit.sv
// branch_predict_unit: branch outcome resolve + direct-mapped BTB with 2-bit counters; BPU_BYPASS_EN enables same-cycle update bypass
module branch_predict_unit #(
   parameter int ENTRIES = 16,
   parameter int PC_W    = 16
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [PC_W-1:0] fetch_pc_i,
   output logic            pred_taken_o,
   output logic [PC_W-1:0] pred_target_o,
   input  logic            res_valid_i,
   input  logic [PC_W-1:0] res_pc_i,
   input  logic [2:0]      res_funct3_i,
   input  logic            br_less_i,
   input  logic            br_equal_i,
   input  logic [PC_W-1:0] res_target_i,
   input  logic            res_pred_taken_i,
   input  logic [PC_W-1:0] res_pred_target_i,
   output logic            res_taken_o,
   output logic            flush_o,
   output logic [PC_W-1:0] redirect_pc_o
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;

   logic             valid_q [ENTRIES];
   logic [TAG_W-1:0] tag_q   [ENTRIES];
   logic [PC_W-1:0]  tgt_q   [ENTRIES];
   logic [1:0]       ctr_q   [ENTRIES];
   logic             flush_q;
   logic [PC_W-1:0]  redirect_q;

   logic [IDX_W-1:0] f_idx, r_idx;
   logic [TAG_W-1:0] f_tag, r_tag, l_tag;
   logic             legal, outcome, upd, r_hit, we, byp, l_valid, flush_d;
   logic [1:0]       ctr_d, l_ctr;
   logic [PC_W-1:0]  tgt_d, l_tgt, redirect_d;

   assign f_idx = fetch_pc_i[IDX_W+1:2];
   assign f_tag = fetch_pc_i[PC_W-1:IDX_W+2];
   assign r_idx = res_pc_i[IDX_W+1:2];
   assign r_tag = res_pc_i[PC_W-1:IDX_W+2];

   always_comb begin
      legal      = res_funct3_i[2:1] != 2'b01;
      // funct3[0] inverts the base condition (BNE/BGE/BGEU)
      outcome    = (res_funct3_i[2] ? br_less_i : br_equal_i) ^ res_funct3_i[0];
      upd        = res_valid_i && legal;
      r_hit      = valid_q[r_idx] && tag_q[r_idx] == r_tag;
      we         = upd && (r_hit || outcome);
      ctr_d      = !r_hit ? 2'b10 :
                   outcome ? (ctr_q[r_idx] == 2'b11 ? 2'b11 : ctr_q[r_idx] + 2'd1) :
                             (ctr_q[r_idx] == 2'b00 ? 2'b00 : ctr_q[r_idx] - 2'd1);
      tgt_d      = outcome ? res_target_i : tgt_q[r_idx];
      flush_d    = upd && (outcome != res_pred_taken_i ||
                           (outcome && res_target_i != res_pred_target_i));
      redirect_d = flush_d ? (outcome ? res_target_i : res_pc_i + PC_W'(4)) : redirect_q;
   end

`ifdef BPU_BYPASS_EN
   assign byp = we && f_idx == r_idx;
`else
   assign byp = 1'b0;
`endif

   always_comb begin
      l_valid       = byp || valid_q[f_idx];
      l_tag         = byp ? r_tag : tag_q[f_idx];
      l_ctr         = byp ? ctr_d : ctr_q[f_idx];
      l_tgt         = byp ? tgt_d : tgt_q[f_idx];
      pred_taken_o  = l_valid && l_tag == f_tag && l_ctr[1];
      pred_target_o = pred_taken_o ? l_tgt : fetch_pc_i + PC_W'(4);
   end

   assign res_taken_o   = upd && outcome;
   assign flush_o       = flush_q;
   assign redirect_pc_o = redirect_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            ctr_q[i]   <= 2'b01;
         end
         flush_q    <= 1'b0;
         redirect_q <= '0;
      end else begin
         flush_q    <= flush_d;
         redirect_q <= redirect_d;
         if (we) begin
            valid_q[r_idx] <= 1'b1;
            tag_q[r_idx]   <= r_tag;
            tgt_q[r_idx]   <= tgt_d;
            ctr_q[r_idx]   <= ctr_d;
         end
      end
   end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed test-plan steps plus random resolves against a BTB reference model
module tb_branch_predict_unit;
   localparam int ENT = 16;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [15:0] fetch_pc_i = '0;
   logic        pred_taken_o;
   logic [15:0] pred_target_o;
   logic        res_valid_i = 1'b0;
   logic [15:0] res_pc_i = '0;
   logic [2:0]  res_funct3_i = '0;
   logic        br_less_i = 1'b0;
   logic        br_equal_i = 1'b0;
   logic [15:0] res_target_i = '0;
   logic        res_pred_taken_i = 1'b0;
   logic [15:0] res_pred_target_i = '0;
   logic        res_taken_o;
   logic        flush_o;
   logic [15:0] redirect_pc_o;

   int checks = 0;
   int errors = 0;

   bit          m_valid [ENT];
   int          m_tag   [ENT];
   logic [15:0] m_tgt   [ENT];
   int          m_ctr   [ENT];
   logic [15:0] m_redir;

   branch_predict_unit #(.ENTRIES(ENT), .PC_W(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .fetch_pc_i(fetch_pc_i),
      .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
      .res_valid_i(res_valid_i), .res_pc_i(res_pc_i), .res_funct3_i(res_funct3_i),
      .br_less_i(br_less_i), .br_equal_i(br_equal_i), .res_target_i(res_target_i),
      .res_pred_taken_i(res_pred_taken_i), .res_pred_target_i(res_pred_target_i),
      .res_taken_o(res_taken_o), .flush_o(flush_o), .redirect_pc_o(redirect_pc_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < ENT; i++) begin
         m_valid[i] = 0;
         m_ctr[i]   = 1;
      end
      m_redir = '0;
   endtask

   task automatic m_lookup(input logic [15:0] pc, output logic t, output logic [15:0] tg);
      int i, tv;
      i  = (int'(pc) / 4) % ENT;
      tv = int'(pc) / (4 * ENT);
      t  = m_valid[i] && m_tag[i] == tv && m_ctr[i] >= 2;
      tg = t ? m_tgt[i] : pc + 16'd4;
   endtask

   // one cycle: drive, check combinational outputs, clock, check registered outputs
   task automatic step(input logic v, input logic [15:0] pc, input logic [2:0] f3,
                       input logic lt, input logic eq, input logic [15:0] tg,
                       input logic pt, input logic [15:0] ptg, input logic [15:0] fpc);
      logic ep, legal, oc, tk, mis;
      logic [15:0] et;
      int i, tv;
      res_valid_i = v; res_pc_i = pc; res_funct3_i = f3; br_less_i = lt; br_equal_i = eq;
      res_target_i = tg; res_pred_taken_i = pt; res_pred_target_i = ptg; fetch_pc_i = fpc;
      #1;
      m_lookup(fpc, ep, et);
      chk("pred_taken", pred_taken_o, ep);
      chk("pred_target", pred_target_o, et);
      legal = 1;
      case (f3)
         3'd0: oc = eq;
         3'd1: oc = !eq;
         3'd4, 3'd6: oc = lt;
         3'd5, 3'd7: oc = !lt;
         default: begin oc = 0; legal = 0; end
      endcase
      tk = v && legal && oc;
      chk("res_taken", res_taken_o, tk);
      mis = v && legal && (tk != pt || (tk && tg != ptg));
      if (mis) m_redir = tk ? tg : pc + 16'd4;
      if (v && legal) begin
         i  = (int'(pc) / 4) % ENT;
         tv = int'(pc) / (4 * ENT);
         if (m_valid[i] && m_tag[i] == tv) begin
            m_ctr[i] = tk ? (m_ctr[i] < 3 ? m_ctr[i] + 1 : 3) : (m_ctr[i] > 0 ? m_ctr[i] - 1 : 0);
            if (tk) m_tgt[i] = tg;
         end else if (tk) begin
            m_valid[i] = 1; m_tag[i] = tv; m_tgt[i] = tg; m_ctr[i] = 2;
         end
      end
      @(posedge clk_i); #1;
      chk("flush", flush_o, mis);
      chk("redirect", redirect_pc_o, m_redir);
   endtask

   task automatic idle(input logic [15:0] fpc);
      step(0, 16'h0, 3'd0, 0, 0, 16'h0, 0, 16'h0, fpc);
   endtask

   initial begin
      logic [15:0] rpc, rtg, ptg;
      logic pt;
      m_reset();
      repeat (2) @(posedge clk_i);
      #1;
      fetch_pc_i = 16'h0040;
      #1;
      chk("rst_pred_taken", pred_taken_o, 1'b0);
      chk("rst_pred_target", pred_target_o, 16'h0044);
      chk("rst_flush", flush_o, 1'b0);
      chk("rst_redirect", redirect_pc_o, 16'h0000);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      // first-taken BEQ mispredict, then lookup shows weakly-taken allocation
      step(1, 16'h0040, 3'd0, 0, 1, 16'h0100, 0, 16'h0044, 16'h0040);
      chk("tp_flush_hi", flush_o, 1'b1);
      chk("tp_redirect", redirect_pc_o, 16'h0100);
      idle(16'h0040);
      chk("tp_flush_one_cycle", flush_o, 1'b0);
      chk("tp_pred_taken", pred_taken_o, 1'b1);
      chk("tp_pred_target", pred_target_o, 16'h0100);
      // counter saturates at 11, not-taken drops to 10 and still predicts taken
      step(1, 16'h0040, 3'd0, 0, 1, 16'h0100, 1, 16'h0100, 16'h0040);
      step(1, 16'h0040, 3'd0, 0, 1, 16'h0100, 1, 16'h0100, 16'h0040);
      step(1, 16'h0040, 3'd0, 0, 0, 16'h0100, 1, 16'h0100, 16'h0040);
      chk("nt_redirect", redirect_pc_o, 16'h0044);
      idle(16'h0040);
      chk("nt_still_taken", pred_taken_o, 1'b1);
      // illegal funct3 ignored
      step(1, 16'h0040, 3'd2, 0, 1, 16'h0300, 1, 16'h0100, 16'h0040);
      chk("ill_no_flush", flush_o, 1'b0);
      step(1, 16'h0040, 3'd3, 1, 1, 16'h0300, 0, 16'h0100, 16'h0040);
      idle(16'h0040);
      chk("ill_unchanged", pred_target_o, 16'h0100);
      // alias with different tag
      idle(16'h0080);
      chk("alias_pred", pred_taken_o, 1'b0);
      chk("alias_target", pred_target_o, 16'h0084);
      // PC+4 wrap
      idle(16'hFFFC);
      chk("wrap_target", pred_target_o, 16'h0000);
      // each branch type
      step(1, 16'h0104, 3'd1, 0, 0, 16'h0200, 0, 16'h0, 16'h0104);
      step(1, 16'h0108, 3'd4, 1, 0, 16'h0300, 1, 16'h0300, 16'h0108);
      step(1, 16'h010C, 3'd5, 1, 0, 16'h0400, 1, 16'h0400, 16'h010C);
      step(1, 16'h0110, 3'd6, 0, 0, 16'h0500, 0, 16'h0, 16'h0110);
      step(1, 16'h0114, 3'd7, 0, 1, 16'h0600, 1, 16'h0700, 16'h0114);
      // target mismatch mispredict, then reset right after the flush edge
      step(1, 16'h0040, 3'd1, 0, 0, 16'h0200, 1, 16'h0100, 16'h0040);
      chk("pre_rst_flush", flush_o, 1'b1);
      rst_ni = 1'b0;
      #1;
      m_reset();
      chk("rst_mid_flush", flush_o, 1'b0);
      chk("rst_mid_redirect", redirect_pc_o, 16'h0000);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      idle(16'h0040);
      chk("post_rst_pred", pred_taken_o, 1'b0);
      // random resolves over a small PC pool to exercise hits, aliases and saturation
      for (int n = 0; n < 600; n++) begin
         rpc = 16'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2));
         rtg = 16'($urandom_range(0, 3) << 8);
         if ($urandom_range(0, 3) != 0) m_lookup(rpc, pt, ptg);
         else begin pt = 1'($urandom); ptg = 16'($urandom); end
         step(1'($urandom_range(0, 4) != 0), rpc, 3'($urandom), 1'($urandom), 1'($urandom),
              rtg, pt, ptg,
              16'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2)));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Consumer side of the branch-compare flags: takes br_less/br_equal from the branch comparator plus the branch funct3 and resolves actual taken/not-taken.
- Holds a direct-mapped BTB with 2-bit saturating counters. Fetch uses it to predict the next PC; execute uses it to resolve branches, train the table and raise a registered flush/redirect on mispredict.
- Sits between the fetch PC mux and the execute-stage comparator.

Parameters:
- ENTRIES, 16, number of BTB entries (power of 2, ≥2); IDX_W = log2(ENTRIES)
- PC_W, 16, PC / target width
- TAG_W, PC_W-IDX_W-2, stored tag width, taken from pc[PC_W-1:IDX_W+2]

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- fetch_pc_i  in  PC_W  PC being fetched
- pred_taken_o  out  1  prediction for fetch_pc_i (combinational)
- pred_target_o  out  PC_W  predicted target; fetch_pc_i+4 when not taken
- res_valid_i  in  1  a branch is resolving this cycle
- res_pc_i  in  PC_W  PC of the resolving branch
- res_funct3_i  in  3  branch type
- br_less_i  in  1  comparator less flag (signedness already applied)
- br_equal_i  in  1  comparator equal flag
- res_target_i  in  PC_W  computed branch target
- res_pred_taken_i  in  1  prediction carried down the pipe with this branch
- res_pred_target_i  in  PC_W  predicted target carried down the pipe
- res_taken_o  out  1  actual outcome (combinational)
- flush_o  out  1  mispredict pulse (registered)
- redirect_pc_o  out  PC_W  correct next PC (registered, valid with flush_o)

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]. Each entry holds valid, tag, target and a 2-bit counter.
- Lookup (combinational): hit = valid && tag match. pred_taken_o = hit && ctr[1]. pred_target_o = pred_taken_o ? entry.target : fetch_pc_i+4, with modulo 2^PC_W wrap.
- Resolve decode of funct3:
  - 000 BEQ: equal
  - 001 BNE: !equal
  - 100 / 110 BLT / BLTU: less
  - 101 / 111 BGE / BGEU: !less
  - 010 / 011: illegal. res_taken_o=0; the resolve is ignored entirely (no training, no flush).
- res_taken_o is the decoded outcome gated by res_valid_i. It is 0 when res_valid_i=0.
- Mispredict = valid legal resolve && (taken != res_pred_taken_i || (taken && res_target_i != res_pred_target_i)).
- Registered outputs: on the clock edge after a mispredicting resolve, flush_o=1 for exactly 1 cycle. redirect_pc_o = taken ? res_target_i : res_pc_i+4. Otherwise flush_o=0 and redirect_pc_o holds its last value.
- Training happens on the same edge, for every valid legal resolve:
  - On tag hit: counter increments if taken (saturates at 11) or decrements if not taken (saturates at 00). Target is overwritten when taken.
  - On miss or invalid entry: allocate only if taken. Set valid=1, tag, target, ctr=10 (weakly taken). A not-taken miss leaves the table unchanged.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents (no bypass unless the optional feature is enabled).
- Reset (async, asserted): all valid bits=0, counters=01, flush_o=0, redirect_pc_o=0. Deassertion is synchronised externally.
- Reset mid-resolve: the pending flush is dropped; no training occurs.
- Back-to-back resolves every cycle are supported. A flush can assert on consecutive cycles.

Optional Feature:
- Macro BPU_BYPASS_EN.
- Defined: when a valid legal resolve trains the entry whose index matches fetch_pc_i's index in the same cycle, the lookup uses the post-update entry contents (counter, tag, valid, target) combinationally.
- Undefined: the lookup always sees the registered table state. Pipeline correctness is unaffected either way; only prediction accuracy changes.

Test Plan:
- Reset, then fetch_pc_i=0x0040 -> pred_taken_o=0, pred_target_o=0x0044, flush_o=0.
- Resolve BEQ at 0x0040, br_equal_i=1, target 0x0100, res_pred_taken_i=0 -> res_taken_o=1; next cycle flush_o=1 for one cycle and redirect_pc_o=0x0100; following fetch of 0x0040 -> pred_taken_o=1, pred_target_o=0x0100 (ctr=10).
- Same branch resolved taken twice, then not-taken with res_pred_taken_i=1 -> counter 11 then 10, pred still taken; the not-taken resolve gives flush_o=1 and redirect_pc_o=0x0044.
- Illegal funct3=010 with br_equal_i=1, res_pred_taken_i=1 -> res_taken_o=0, no flush, table unchanged.
- Alias: train taken at 0x0040 (ENTRIES=16), then fetch 0x0080 (same index, different tag) -> pred_taken_o=0, pred_target_o=0x0084.
- Assert rst_ni low on the cycle right after a mispredicting resolve edge -> flush_o drops to 0 immediately; after reset, fetch of 0x0040 predicts not taken.
